pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It drives the enable and clear inputs of the PC register and the four pipeline registers (F/D, D/E, E/M, M/W). It resolves load-use and multiply/divide stalls and sequences the flush/redirect on an exception, interrupt or `eret` signalled at the M stage. It owns the multiply/divide busy counter, so the D-stage stall decision has one source.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/md_busy_counter.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    // Controller state: normal running, or the single cycle after a flush.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    // Next-PC source codes driven on pc_sel.
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_EXC = 2'b01;
    localparam logic [1:0] PC_EPC = 2'b10;

    // Exception handler entry point selected by PC_EXC.
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    // Width of the multiply/divide busy counter.
    localparam int CNT_W = 4;

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads the operation latency when a mult/div
// enters E and counts down to zero; md_busy flags a non-zero count.
module md_busy_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt;

    // Load on start (a start while busy simply reloads), otherwise count down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: drives PC/pipeline register enables and
// clears, resolving load-use and mult/div stalls and sequencing the flush and
// redirect for exceptions and eret taken at M.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_use_hz,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       md_use_D,
    input  logic       exc_req_M,
    input  logic       eret_M,
    output logic       pc_en,
    output logic       en_FD,
    output logic       en_DE,
    output logic       en_EM,
    output logic       en_MW,
    output logic       clr_FD,
    output logic       clr_DE,
    output logic       clr_EM,
    output logic       clr_MW,
    output logic [1:0] pc_sel,
    output logic       md_busy
);

    state_t state;
    state_t state_next;
    logic   take_exc;
    logic   take_eret;
    logic   flush;
    logic   stall;
    logic   md_start_q;

    // M-stage requests are honoured only in RUN; in REDIRECT M holds a bubble.
    assign take_exc   = (state == ST_RUN) && exc_req_M;
    assign take_eret  = (state == ST_RUN) && eret_M && !exc_req_M;
    assign flush      = take_exc || take_eret;
    assign stall      = !flush && (((md_busy || md_start) && md_use_D) || load_use_hz);
    // A flush kills the instruction in E, so its mult/div never starts.
    assign md_start_q = md_start && !flush;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start_q),
        .is_div  (md_is_div),
        .md_busy (md_busy)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a taken flush redirects for exactly one cycle.
    always_comb begin
        state_next = ST_RUN;
        if (state == ST_RUN && flush) begin
            state_next = ST_REDIRECT;
        end
    end

    // Outputs: flush beats stall; during reset everything sits at run defaults.
    always_comb begin
        pc_en  = 1'b1;
        en_FD  = 1'b1;
        en_DE  = 1'b1;
        en_EM  = 1'b1;
        en_MW  = 1'b1;
        clr_FD = 1'b0;
        clr_DE = 1'b0;
        clr_EM = 1'b0;
        clr_MW = 1'b0;
        pc_sel = PC_SEQ;
        if (reset) begin
            if (take_exc) begin
                clr_FD = 1'b1;
                clr_DE = 1'b1;
                clr_EM = 1'b1;
                clr_MW = 1'b1;
                pc_sel = PC_EXC;
            end else if (take_eret) begin
                clr_FD = 1'b1;
                clr_DE = 1'b1;
                clr_EM = 1'b1;
                pc_sel = PC_EPC;
            end else if (stall) begin
                pc_en  = 1'b0;
                en_FD  = 1'b0;
                clr_DE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies directed vectors and
// queues hand-computed expected outputs; a monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_use_hz, md_start, md_is_div, md_use_D, exc_req_M, eret_M;
    logic       pc_en, en_FD, en_DE, en_EM, en_MW;
    logic       clr_FD, clr_DE, clr_EM, clr_MW;
    logic [1:0] pc_sel;
    logic       md_busy;

    // {pc_en,en_FD,en_DE,en_EM,en_MW, clr_FD,clr_DE,clr_EM,clr_MW, pc_sel, md_busy}
    localparam logic [11:0] E_RUN   = 12'b11111_0000_00_0;
    localparam logic [11:0] E_STALL = 12'b00111_0100_00_0;
    localparam logic [11:0] E_EXC   = 12'b11111_1111_01_0;
    localparam logic [11:0] E_ERET  = 12'b11111_1110_10_0;

    typedef struct {
        logic [11:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_use_hz (load_use_hz),
        .md_start    (md_start),
        .md_is_div   (md_is_div),
        .md_use_D    (md_use_D),
        .exc_req_M   (exc_req_M),
        .eret_M      (eret_M),
        .pc_en       (pc_en),
        .en_FD       (en_FD),
        .en_DE       (en_DE),
        .en_EM       (en_EM),
        .en_MW       (en_MW),
        .clr_FD      (clr_FD),
        .clr_DE      (clr_DE),
        .clr_EM      (clr_EM),
        .clr_MW      (clr_MW),
        .pc_sel      (pc_sel),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the rising edge and queue expectation.
    task automatic step(input string name, input logic rn, input logic lu,
                        input logic ms, input logic dv, input logic use_d,
                        input logic exc, input logic er,
                        input logic [11:0] base, input logic busy);
        item_t it;
        @(posedge clk);
        #1;
        reset       = rn;
        load_use_hz = lu;
        md_start    = ms;
        md_is_div   = dv;
        md_use_D    = use_d;
        exc_req_M   = exc;
        eret_M      = er;
        it.exp      = base | {11'b0, busy};
        it.name     = name;
        q.push_back(it);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        item_t it;
        logic [11:0] act;
        if (q.size() > 0) begin
            it  = q.pop_front();
            act = {pc_en, en_FD, en_DE, en_EM, en_MW,
                   clr_FD, clr_DE, clr_EM, clr_MW, pc_sel, md_busy};
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end
        end
    end

    initial begin
        reset = 1'b0; load_use_hz = 0; md_start = 0; md_is_div = 0;
        md_use_D = 0; exc_req_M = 0; eret_M = 0;

        // Reset held, including with hazards present.
        step("rst_idle",   0, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        step("rst_hz",     0, 1, 1, 0, 1, 1, 0, E_RUN, 0);
        step("rst_idle2",  0, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Run, no hazards.
        for (int i = 0; i < 3; i++) step("run_idle", 1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Load-use: one-cycle stall.
        step("lu_stall",   1, 1, 0, 0, 0, 0, 0, E_STALL, 0);
        step("lu_after",   1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Mult then mflo.
        step("mult_t",     1, 0, 1, 0, 1, 0, 0, E_STALL, 0);
        for (int i = 1; i <= 5; i++) step("mult_busy", 1, 0, 0, 0, 1, 0, 0, E_STALL, 1);
        step("mult_done",  1, 0, 0, 0, 1, 0, 0, E_RUN, 0);
        step("mult_idle",  1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Div then mflo.
        step("div_t",      1, 0, 1, 1, 1, 0, 0, E_STALL, 0);
        for (int i = 1; i <= 10; i++) step("div_busy", 1, 0, 0, 0, 1, 0, 0, E_STALL, 1);
        step("div_done",   1, 0, 0, 0, 1, 0, 0, E_RUN, 0);
        step("div_idle",   1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Exception, then a second request ignored in REDIRECT.
        step("exc",        1, 0, 0, 0, 0, 1, 0, E_EXC, 0);
        step("exc_redir",  1, 0, 0, 0, 0, 1, 0, E_RUN, 0);
        step("exc_after",  1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Eret beats a load-use stall; eret ignored in REDIRECT.
        step("eret",       1, 1, 0, 0, 0, 0, 1, E_ERET, 0);
        step("eret_redir", 1, 0, 0, 0, 0, 0, 1, E_RUN, 0);
        // Everything at once: exception wins, counter never loads.
        step("all_exc",    1, 0, 1, 1, 0, 1, 1, E_EXC, 0);
        step("all_after",  1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        step("all_after2", 1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Div at t, exception at t+2, stall during REDIRECT at t+3.
        step("dx_t",       1, 0, 1, 1, 0, 0, 0, E_RUN, 0);
        step("dx_t1",      1, 0, 0, 0, 0, 0, 0, E_RUN, 1);
        step("dx_exc",     1, 0, 0, 0, 0, 1, 0, E_EXC, 1);
        step("dx_redir_st",1, 0, 0, 0, 1, 0, 0, E_STALL, 1);
        for (int i = 4; i <= 10; i++) step("dx_busy", 1, 0, 0, 0, 0, 0, 0, E_RUN, 1);
        step("dx_done",    1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Reset mid-stall clears outputs at once and empties the counter.
        step("mr_mult",    1, 0, 1, 0, 1, 0, 0, E_STALL, 0);
        step("mr_busy",    1, 0, 0, 0, 1, 0, 0, E_STALL, 1);
        step("mr_reset",   0, 1, 0, 0, 1, 0, 0, E_RUN, 0);
        step("mr_release", 1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        // Reset during REDIRECT returns the FSM to RUN.
        step("rr_exc",     1, 0, 0, 0, 0, 1, 0, E_EXC, 0);
        step("rr_reset",   0, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        step("rr_eret",    1, 0, 0, 0, 0, 0, 1, E_ERET, 0);
        step("rr_idle",    1, 0, 0, 0, 0, 0, 0, E_RUN, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d items left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
